// File: rtl/fox_packet_pkg.sv
// Purpose : shared Fox network packet definitions (field widths, packing order, bit offsets,
//           pack/unpack helpers) for the transmit scheduler and the receive side.
// Latency : n/a (package).  Backpressure: n/a.
// Packing, MSB to LSB: x, y, multicast, done, result, matrix_type, matrix_x, matrix_y, element.
package fox_packet_pkg;

  localparam int FOX_COORD_BITS           = 1;
  localparam int FOX_MULTICAST_GROUP_BITS = 1;
  localparam int FOX_MATRIX_TYPE_BITS     = 1;
  localparam int FOX_MATRIX_COORD_BITS    = 8;
  localparam int FOX_MATRIX_ELEMENT_BITS  = 32;

  // Total packet width for any field-width combination (the two flags are 1 bit each).
  function automatic int fox_packet_bits(input int cb, input int mgb, input int mtb,
                                         input int mcb, input int meb);
    return 2*cb + mgb + 2 + mtb + 2*mcb + meb;
  endfunction

  localparam int FOX_PACKET_BITS = fox_packet_bits(FOX_COORD_BITS, FOX_MULTICAST_GROUP_BITS,
                                                   FOX_MATRIX_TYPE_BITS, FOX_MATRIX_COORD_BITS,
                                                   FOX_MATRIX_ELEMENT_BITS);

  // Field LSB positions at the default widths.
  localparam int FOX_ELEM_LSB   = 0;
  localparam int FOX_MY_LSB     = FOX_ELEM_LSB + FOX_MATRIX_ELEMENT_BITS;
  localparam int FOX_MX_LSB     = FOX_MY_LSB + FOX_MATRIX_COORD_BITS;
  localparam int FOX_MTYPE_LSB  = FOX_MX_LSB + FOX_MATRIX_COORD_BITS;
  localparam int FOX_RESULT_LSB = FOX_MTYPE_LSB + FOX_MATRIX_TYPE_BITS;
  localparam int FOX_DONE_LSB   = FOX_RESULT_LSB + 1;
  localparam int FOX_MCAST_LSB  = FOX_DONE_LSB + 1;
  localparam int FOX_Y_LSB      = FOX_MCAST_LSB + FOX_MULTICAST_GROUP_BITS;
  localparam int FOX_X_LSB      = FOX_Y_LSB + FOX_COORD_BITS;

  typedef struct packed {
    logic [FOX_COORD_BITS-1:0]           x_coord;
    logic [FOX_COORD_BITS-1:0]           y_coord;
    logic [FOX_MULTICAST_GROUP_BITS-1:0] multicast_group;
    logic                                done_flag;
    logic                                result_flag;
    logic [FOX_MATRIX_TYPE_BITS-1:0]     matrix_type;
    logic [FOX_MATRIX_COORD_BITS-1:0]    matrix_x_coord;
    logic [FOX_MATRIX_COORD_BITS-1:0]    matrix_y_coord;
    logic [FOX_MATRIX_ELEMENT_BITS-1:0]  matrix_element;
  } fox_pkt_t;

  function automatic logic [FOX_PACKET_BITS-1:0] fox_pack(input fox_pkt_t p);
    return p;
  endfunction

  function automatic fox_pkt_t fox_unpack(input logic [FOX_PACKET_BITS-1:0] b);
    return fox_pkt_t'(b);
  endfunction

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } fox_tx_state_e;

endpackage

// File: rtl/fox_pkt_fifo.sv
// Purpose : synchronous packet FIFO with occupancy count; pointers wrap modulo DEPTH.
// Latency : pushed word visible at o_head the cycle after the push edge (when it is the head).
// Backpressure: caller may push when full only if it pops in the same cycle (slot reused).
// Ports: clk, rst_n (async active-low), i_push/i_pop strobes, i_dat in, o_head (head word), o_count.
module fox_pkt_fifo #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage needs no reset: the head is only consumed while the count says it is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // With push+pop on a full FIFO, wr_ptr == rd_ptr: the head is read from the old contents
  // this cycle and overwritten at the edge, exactly when rd_ptr moves past it.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fox_packet_tx_scheduler.sv
// Purpose : stages processor field writes, assembles a packet on packet_complete_in, queues it
//           and offers it to the Hoplite router injection port.
// Latency : packet_complete_in at edge N on an empty queue -> pkt_out_valid after edge N+1;
//           1 packet/cycle sustained with pkt_out_ready high.
// Backpressure: message_out_ready = queue not full (registered); a packet_complete_in that finds
//           the queue full without a same-cycle dequeue is dropped and sets sticky overflow.
// Ports: clk, reset_n (async active-low); *_in/*_valid field writes; packet_complete_in;
//        pkt_out/pkt_out_valid/pkt_out_ready router handshake; message_out_ready; overflow.
// Optional: define FOX_TX_STATS_EN to add tx_sent_count and tx_stall_cycles (saturating).
module fox_packet_tx_scheduler
  import fox_packet_pkg::*;
#(
  parameter int COORD_BITS           = FOX_COORD_BITS,
  parameter int MULTICAST_GROUP_BITS = FOX_MULTICAST_GROUP_BITS,
  parameter int MATRIX_TYPE_BITS     = FOX_MATRIX_TYPE_BITS,
  parameter int MATRIX_COORD_BITS    = FOX_MATRIX_COORD_BITS,
  parameter int MATRIX_ELEMENT_BITS  = FOX_MATRIX_ELEMENT_BITS,
  parameter int FIFO_DEPTH           = 4,
  localparam int PACKET_BITS = fox_packet_bits(COORD_BITS, MULTICAST_GROUP_BITS, MATRIX_TYPE_BITS,
                                               MATRIX_COORD_BITS, MATRIX_ELEMENT_BITS),
  localparam int CNT_BITS    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [PACKET_BITS-1:0]          pkt_out,
  output logic                            pkt_out_valid,
  input  logic                            pkt_out_ready,
  output logic                            overflow
`ifdef FOX_TX_STATS_EN
  ,
  output logic [31:0]                     tx_sent_count,
  output logic [31:0]                     tx_stall_cycles
`endif
);

  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(FIFO_DEPTH);

  // ---------------- staging registers ----------------
  logic [COORD_BITS-1:0]           r_x_coord, r_y_coord;
  logic [MULTICAST_GROUP_BITS-1:0] r_multicast_group;
  logic                            r_done_flag, r_result_flag;
  logic [MATRIX_TYPE_BITS-1:0]     r_matrix_type;
  logic [MATRIX_COORD_BITS-1:0]    r_matrix_x_coord, r_matrix_y_coord;
  logic [MATRIX_ELEMENT_BITS-1:0]  r_matrix_element;

  // Fields stay loaded after an enqueue so firmware rewrites only what changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_coord         <= '0;
      r_y_coord         <= '0;
      r_multicast_group <= '0;
      r_done_flag       <= 1'b0;
      r_result_flag     <= 1'b0;
      r_matrix_type     <= '0;
      r_matrix_x_coord  <= '0;
      r_matrix_y_coord  <= '0;
      r_matrix_element  <= '0;
    end else begin
      if (x_coord_in_valid)         r_x_coord         <= x_coord_in;
      if (y_coord_in_valid)         r_y_coord         <= y_coord_in;
      if (multicast_group_in_valid) r_multicast_group <= multicast_group_in;
      if (done_flag_in_valid)       r_done_flag       <= done_flag_in;
      if (result_flag_in_valid)     r_result_flag     <= result_flag_in;
      if (matrix_type_in_valid)     r_matrix_type     <= matrix_type_in;
      if (matrix_x_coord_in_valid)  r_matrix_x_coord  <= matrix_x_coord_in;
      if (matrix_y_coord_in_valid)  r_matrix_y_coord  <= matrix_y_coord_in;
      if (matrix_element_in_valid)  r_matrix_element  <= matrix_element_in;
    end
  end

  // A field written in the same cycle as packet_complete_in goes straight into the packet.
  logic [PACKET_BITS-1:0] w_pkt;
  assign w_pkt = {
    x_coord_in_valid         ? x_coord_in         : r_x_coord,
    y_coord_in_valid         ? y_coord_in         : r_y_coord,
    multicast_group_in_valid ? multicast_group_in : r_multicast_group,
    done_flag_in_valid       ? done_flag_in       : r_done_flag,
    result_flag_in_valid     ? result_flag_in     : r_result_flag,
    matrix_type_in_valid     ? matrix_type_in     : r_matrix_type,
    matrix_x_coord_in_valid  ? matrix_x_coord_in  : r_matrix_x_coord,
    matrix_y_coord_in_valid  ? matrix_y_coord_in  : r_matrix_y_coord,
    matrix_element_in_valid  ? matrix_element_in  : r_matrix_element
  };

  // ---------------- queue ----------------
  fox_tx_state_e           r_state, w_state_next;
  logic [PACKET_BITS-1:0]  w_head;
  logic [CNT_BITS-1:0]     w_count, w_count_next;
  logic                    w_full, w_push, w_pop;

  assign w_full = (w_count == FULL_CNT);
  assign w_pop  = (r_state == TX_SEND) && pkt_out_ready;
  // A full queue still takes a packet when the head leaves in the same cycle.
  assign w_push = packet_complete_in && (!w_full || w_pop);

  fox_pkt_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_pkt),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_pop)      w_count_next = w_count + CNT_BITS'(1);
    else if (!w_push && w_pop) w_count_next = w_count - CNT_BITS'(1);
  end

  // ---------------- output FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= TX_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    pkt_out_valid     = 1'b0;
    pkt_out           = '0;
    message_out_ready = !w_full;
    case (r_state)
      TX_IDLE: begin
        if (w_count != '0) w_state_next = TX_SEND;
      end
      TX_SEND: begin
        pkt_out_valid = 1'b1;
        pkt_out       = w_head;
        // Count after the pop includes any same-cycle push, so back-to-back traffic stays in SEND.
        if (w_pop && (w_count_next == '0)) w_state_next = TX_IDLE;
      end
      default: w_state_next = TX_IDLE;
    endcase
  end

  // ---------------- overflow ----------------
  logic r_overflow;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_overflow <= 1'b0;
    else if (packet_complete_in && !w_push) r_overflow <= 1'b1;
  end
  assign overflow = r_overflow;

`ifdef FOX_TX_STATS_EN
  // ---------------- statistics (saturating) ----------------
  logic [31:0] r_tx_sent_count, r_tx_stall_cycles;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_sent_count   <= '0;
      r_tx_stall_cycles <= '0;
    end else begin
      if (w_pop && (r_tx_sent_count != '1))
        r_tx_sent_count <= r_tx_sent_count + 32'd1;
      if (pkt_out_valid && !pkt_out_ready && (r_tx_stall_cycles != '1))
        r_tx_stall_cycles <= r_tx_stall_cycles + 32'd1;
    end
  end
  assign tx_sent_count   = r_tx_sent_count;
  assign tx_stall_cycles = r_tx_stall_cycles;
`endif

endmodule

// File: tb/tb_fox_packet_tx_scheduler.sv
// Bench for fox_packet_tx_scheduler: directed vector table, hand-written multi-cycle sequences
// (async reset mid-stall, statistics) and randomized traffic against a queue-based reference model.
module tb_fox_packet_tx_scheduler;

  localparam int D  = 4;
  localparam int PB = 54;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid;
  logic        multicast_group_in, multicast_group_in_valid;
  logic        done_flag_in, done_flag_in_valid, result_flag_in, result_flag_in_valid;
  logic        matrix_type_in, matrix_type_in_valid;
  logic [7:0]  matrix_x_coord_in, matrix_y_coord_in;
  logic        matrix_x_coord_in_valid, matrix_y_coord_in_valid;
  logic [31:0] matrix_element_in;
  logic        matrix_element_in_valid;
  logic        packet_complete_in;
  logic        message_out_ready;
  logic [PB-1:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic        overflow;
`ifdef FOX_TX_STATS_EN
  logic [31:0] tx_sent_count, tx_stall_cycles;
`endif

  fox_packet_tx_scheduler dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .x_coord_in              (x_coord_in),
    .x_coord_in_valid        (x_coord_in_valid),
    .y_coord_in              (y_coord_in),
    .y_coord_in_valid        (y_coord_in_valid),
    .multicast_group_in      (multicast_group_in),
    .multicast_group_in_valid(multicast_group_in_valid),
    .done_flag_in            (done_flag_in),
    .done_flag_in_valid      (done_flag_in_valid),
    .result_flag_in          (result_flag_in),
    .result_flag_in_valid    (result_flag_in_valid),
    .matrix_type_in          (matrix_type_in),
    .matrix_type_in_valid    (matrix_type_in_valid),
    .matrix_x_coord_in       (matrix_x_coord_in),
    .matrix_x_coord_in_valid (matrix_x_coord_in_valid),
    .matrix_y_coord_in       (matrix_y_coord_in),
    .matrix_y_coord_in_valid (matrix_y_coord_in_valid),
    .matrix_element_in       (matrix_element_in),
    .matrix_element_in_valid (matrix_element_in_valid),
    .packet_complete_in      (packet_complete_in),
    .message_out_ready       (message_out_ready),
    .pkt_out                 (pkt_out),
    .pkt_out_valid           (pkt_out_valid),
    .pkt_out_ready           (pkt_out_ready),
    .overflow                (overflow)
`ifdef FOX_TX_STATS_EN
    ,
    .tx_sent_count           (tx_sent_count),
    .tx_stall_cycles         (tx_stall_cycles)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: a queue of whole packets ----------------
  logic [PB-1:0] mq[$];
  bit            m_vld, m_ovf;
  logic          m_x, m_y, m_mc, m_done, m_res, m_mt;
  logic [7:0]    m_mx, m_my;
  logic [31:0]   m_el, m_sent, m_stall;

  task automatic model_reset();
    mq.delete();
    m_vld = 0; m_ovf = 0;
    m_x = 0; m_y = 0; m_mc = 0; m_done = 0; m_res = 0; m_mt = 0;
    m_mx = '0; m_my = '0; m_el = '0; m_sent = '0; m_stall = '0;
  endtask

  task automatic clear_in();
    x_coord_in_valid = 0; y_coord_in_valid = 0; multicast_group_in_valid = 0;
    done_flag_in_valid = 0; result_flag_in_valid = 0; matrix_type_in_valid = 0;
    matrix_x_coord_in_valid = 0; matrix_y_coord_in_valid = 0; matrix_element_in_valid = 0;
    packet_complete_in = 0;
  endtask

  task automatic check_model();
    logic [PB-1:0] exp_pkt;
    exp_pkt = m_vld ? mq[0] : '0;
    chk("model_valid",    64'(pkt_out_valid),     64'(m_vld));
    chk("model_pkt",      64'(pkt_out),           64'(exp_pkt));
    chk("model_msg_rdy",  64'(message_out_ready), 64'(mq.size() != D));
    chk("model_overflow", 64'(overflow),          64'(m_ovf));
`ifdef FOX_TX_STATS_EN
    chk("model_sent",     64'(tx_sent_count),     64'(m_sent));
    chk("model_stall",    64'(tx_stall_cycles),   64'(m_stall));
`endif
  endtask

  // Inputs are already driven; advance one edge, update the model, compare.
  task automatic step();
    bit pop, acc;
    int szb;
    logic bx, by, bmc, bd, br, bmt;
    logic [7:0] bmx, bmy;
    logic [31:0] bel;
    logic [PB-1:0] p;
    bx  = x_coord_in_valid         ? x_coord_in         : m_x;
    by  = y_coord_in_valid         ? y_coord_in         : m_y;
    bmc = multicast_group_in_valid ? multicast_group_in : m_mc;
    bd  = done_flag_in_valid       ? done_flag_in       : m_done;
    br  = result_flag_in_valid     ? result_flag_in     : m_res;
    bmt = matrix_type_in_valid     ? matrix_type_in     : m_mt;
    bmx = matrix_x_coord_in_valid  ? matrix_x_coord_in  : m_mx;
    bmy = matrix_y_coord_in_valid  ? matrix_y_coord_in  : m_my;
    bel = matrix_element_in_valid  ? matrix_element_in  : m_el;
    p   = {bx, by, bmc, bd, br, bmt, bmx, bmy, bel};
    pop = m_vld && pkt_out_ready;
    szb = mq.size();
    acc = packet_complete_in && ((szb < D) || pop);
    if (m_vld && !pkt_out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
    if (pop && (m_sent != 32'hFFFF_FFFF)) m_sent = m_sent + 1;
    @(posedge clk); #1;
    m_x = bx; m_y = by; m_mc = bmc; m_done = bd; m_res = br; m_mt = bmt;
    m_mx = bmx; m_my = bmy; m_el = bel;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(p);
    if (packet_complete_in && !acc) m_ovf = 1;
    // Valid rises one cycle after the queue becomes non-empty and falls only after the last pop.
    if (m_vld) m_vld = pop ? (mq.size() > 0) : 1'b1;
    else       m_vld = (szb > 0);
    check_model();
  endtask

  // Called a cycle-fraction after a rising edge; reset asserted between edges.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_valid",    64'(pkt_out_valid),     64'd0);
    chk("rst_pkt",      64'(pkt_out),           64'd0);
    chk("rst_msg_rdy",  64'(message_out_ready), 64'd1);
    chk("rst_overflow", 64'(overflow),          64'd0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rs; bit xv; bit x; bit ev; logic [31:0] e; bit pc; bit rdy;
    bit ex_vld; logic [31:0] ex_el; bit ex_x; bit ex_mor; bit ex_ovf;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit rs, input bit xv, input bit x, input bit ev, input logic [31:0] e,
                     input bit pc, input bit rdy, input bit vld, input logic [31:0] el,
                     input bit ex, input bit mor, input bit ovf);
    vec_t v;
    v.rs = rs; v.xv = xv; v.x = x; v.ev = ev; v.e = e; v.pc = pc; v.rdy = rdy;
    v.ex_vld = vld; v.ex_el = el; v.ex_x = ex; v.ex_mor = mor; v.ex_ovf = ovf;
    vt.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0;
    clear_in();
    x_coord_in = 0; y_coord_in = 0; multicast_group_in = 0; done_flag_in = 0;
    result_flag_in = 0; matrix_type_in = 0; matrix_x_coord_in = '0; matrix_y_coord_in = '0;
    matrix_element_in = '0; pkt_out_ready = 0;
    model_reset();

    //   rs xv x ev e             pc rdy | vld el           x mor ovf
    // single packet, x=1, element 0xDEADBEEF: valid for exactly one cycle
    add(1, 1, 1, 1, 32'hDEADBEEF, 1, 1,   0, 32'h0,        0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'hDEADBEEF, 1, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,        0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,        0, 1, 0);
    // fill 4 with ready low, 5th dropped -> overflow, then drain 1..4 in order
    add(0, 0, 0, 1, 32'd1,        1, 0,   0, 32'h0,        0, 1, 0);
    add(0, 0, 0, 1, 32'd2,        1, 0,   1, 32'd1,        1, 1, 0);
    add(0, 0, 0, 1, 32'd3,        1, 0,   1, 32'd1,        1, 1, 0);
    add(0, 0, 0, 1, 32'd4,        1, 0,   1, 32'd1,        1, 0, 0);
    add(0, 0, 0, 1, 32'd5,        1, 0,   1, 32'd1,        1, 0, 1);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'd2,        1, 1, 1);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'd3,        1, 1, 1);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'd4,        1, 1, 1);
    add(0, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,        0, 1, 1);
    // full queue: enqueue with a same-cycle dequeue is accepted, no overflow
    add(1, 0, 0, 1, 32'd11,       1, 0,   0, 32'h0,        0, 1, 0);
    add(0, 0, 0, 1, 32'd12,       1, 0,   1, 32'd11,       0, 1, 0);
    add(0, 0, 0, 1, 32'd13,       1, 0,   1, 32'd11,       0, 1, 0);
    add(0, 0, 0, 1, 32'd14,       1, 0,   1, 32'd11,       0, 0, 0);
    add(0, 0, 0, 1, 32'd15,       1, 1,   1, 32'd12,       0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 0,   1, 32'd12,       0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'd13,       0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'd14,       0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'd15,       0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,        0, 1, 0);
    // same-cycle element write bypass, then repeat from staging
    add(1, 0, 0, 1, 32'd7,        1, 1,   0, 32'h0,        0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        1, 1,   1, 32'd7,        0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   1, 32'd7,        0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,        0, 1, 0);

    @(posedge clk); #1;
    foreach (vt[i]) begin
      if (vt[i].rs) do_reset();
      clear_in();
      x_coord_in_valid        = vt[i].xv;
      x_coord_in              = vt[i].x;
      matrix_element_in_valid = vt[i].ev;
      matrix_element_in       = vt[i].e;
      packet_complete_in      = vt[i].pc;
      pkt_out_ready           = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i),    64'(pkt_out_valid),     64'(vt[i].ex_vld));
      chk($sformatf("vec%0d_element", i),  64'(pkt_out[31:0]),     64'(vt[i].ex_el));
      chk($sformatf("vec%0d_x", i),        64'(pkt_out[PB-1]),     64'(vt[i].ex_x));
      chk($sformatf("vec%0d_msg_rdy", i),  64'(message_out_ready), 64'(vt[i].ex_mor));
      chk($sformatf("vec%0d_overflow", i), 64'(overflow),          64'(vt[i].ex_ovf));
    end

    // ---------------- statistics: 3 sent, 5 stall cycles ----------------
    do_reset();
    clear_in();
    pkt_out_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      matrix_element_in_valid = 1; matrix_element_in = 32'(k); packet_complete_in = 1;
      step();
    end
    clear_in();
    for (int k = 0; k < 4; k++) step();
    pkt_out_ready = 1;
    for (int k = 0; k < 4; k++) step();
    chk("drain_idle_valid", 64'(pkt_out_valid), 64'd0);
`ifdef FOX_TX_STATS_EN
    chk("stats_sent",  64'(tx_sent_count),   64'd3);
    chk("stats_stall", 64'(tx_stall_cycles), 64'd5);
`endif

    // ---------------- async reset in the middle of a stall ----------------
    do_reset();
    clear_in();
    pkt_out_ready = 0;
    matrix_element_in_valid = 1; matrix_element_in = 32'h55; packet_complete_in = 1;
    step();
    clear_in();
    for (int k = 0; k < 5; k++) step();
    chk("stall_valid_high", 64'(pkt_out_valid), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_valid",   64'(pkt_out_valid),     64'd0);
    chk("async_rst_msg_rdy", 64'(message_out_ready), 64'd1);
    chk("async_rst_pkt",     64'(pkt_out),           64'd0);
    model_reset();
    #1 reset_n = 1'b1;
    pkt_out_ready = 1;
    for (int k = 0; k < 3; k++) step();
    chk("post_rst_empty", 64'(pkt_out_valid), 64'd0);

    // ---------------- randomized traffic against the model ----------------
    do_reset();
    for (int n = 0; n < 600; n++) begin
      clear_in();
      x_coord_in_valid         = ($urandom_range(0, 9) < 3); x_coord_in         = 1'($urandom);
      y_coord_in_valid         = ($urandom_range(0, 9) < 3); y_coord_in         = 1'($urandom);
      multicast_group_in_valid = ($urandom_range(0, 9) < 3); multicast_group_in = 1'($urandom);
      done_flag_in_valid       = ($urandom_range(0, 9) < 3); done_flag_in       = 1'($urandom);
      result_flag_in_valid     = ($urandom_range(0, 9) < 3); result_flag_in     = 1'($urandom);
      matrix_type_in_valid     = ($urandom_range(0, 9) < 3); matrix_type_in     = 1'($urandom);
      matrix_x_coord_in_valid  = ($urandom_range(0, 9) < 3); matrix_x_coord_in  = 8'($urandom);
      matrix_y_coord_in_valid  = ($urandom_range(0, 9) < 3); matrix_y_coord_in  = 8'($urandom);
      matrix_element_in_valid  = ($urandom_range(0, 9) < 5); matrix_element_in  = $urandom;
      packet_complete_in       = ($urandom_range(0, 9) < 4);
      // Low-ready phase fills the queue and exercises overflow, high-ready phase drains it.
      pkt_out_ready = (n < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
